axi_mem_responder: RTL and testbench

- AXI4 responder (slave) backed by on-chip byte-enabled block RAM.
- Serves the 32-bit address / 64-bit data / 6-bit ID AXI bus that swervolf_core drives toward external memory.
- Used as a DDR-less memory target for simulation and for bring-up builds that skip litedram.
- Sits in the clk_core domain; handles one transaction at a time.

---
 rtl/axi_mem_pkg.sv | 36 +++
 rtl/axi_mem_bram.sv | 28 ++
 rtl/axi_mem_responder.sv | 217 +++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Shared constants, FSM state type and address-stepping helper for the
// AXI4 block-RAM responder.
package axi_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      WR_DATA,
      WR_RESP,
      RD_ISSUE,
      RD_DATA
   } state_t;

   // Address of the next beat. WRAP bursts are served as INCR; the 32-bit
   // register is allowed to roll over.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      logic [31:0] incr;
      incr = addr + (32'd1 << size);
      case (burst)
         BURST_FIXED: return addr;
         BURST_INCR:  return incr;
         BURST_WRAP:  return incr;
         default:     return incr;
      endcase
   endfunction

endpackage

// File: rtl/axi_mem_bram.sv
// 64-bit wide single-port block RAM with per-byte write enables and a
// registered read port.
module axi_mem_bram #(
   parameter int unsigned DEPTH     = 8192,
   parameter int unsigned AW        = 13,
   parameter              INIT_FILE = ""
) (
   input  logic          clk,
   input  logic [7:0]    we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];

   // Byte-lane writes and registered read.
   // NOTE: the array has no reset so it maps onto block RAM and keeps its
   // contents across a core reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
         if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 responder backed by on-chip block RAM. Serves one transaction at a
// time; simultaneous write/read requests are granted alternately.
module axi_mem_responder
   import axi_mem_pkg::*;
#(
   parameter int unsigned RAM_SIZE  = 32'h10000,
   parameter int unsigned ID_WIDTH  = 6,
   parameter              INIT_FILE = ""
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ID_WIDTH-1:0] i_awid,
   input  logic [31:0]         i_awaddr,
   input  logic [7:0]          i_awlen,
   input  logic [2:0]          i_awsize,
   input  logic [1:0]          i_awburst,
   input  logic                i_awvalid,
   output logic                o_awready,
   input  logic [ID_WIDTH-1:0] i_arid,
   input  logic [31:0]         i_araddr,
   input  logic [7:0]          i_arlen,
   input  logic [2:0]          i_arsize,
   input  logic [1:0]          i_arburst,
   input  logic                i_arvalid,
   output logic                o_arready,
   input  logic [63:0]         i_wdata,
   input  logic [7:0]          i_wstrb,
   input  logic                i_wlast,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic [ID_WIDTH-1:0] o_bid,
   output logic [1:0]          o_bresp,
   output logic                o_bvalid,
   input  logic                i_bready,
   output logic [ID_WIDTH-1:0] o_rid,
   output logic [63:0]         o_rdata,
   output logic [1:0]          o_rresp,
   output logic                o_rlast,
   output logic                o_rvalid,
   input  logic                i_rready
);

   localparam int unsigned WORDS = RAM_SIZE / 8;
   localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_t              state;
   logic                prio_rd;      // 0: write wins a tie, 1: read wins
   logic                is_wr;
   logic [ID_WIDTH-1:0] id_q;
   logic [31:0]         addr_q;
   logic [7:0]          len_q;
   logic [7:0]          beat_q;
   logic [2:0]          size_q;
   logic [1:0]          burst_q;
   logic                err_q;
   logic                rdata_en_q;   // gates RAM output onto o_rdata

   logic                grant_wr;
   logic                addr_oor;
   logic                w_fire;
   logic                w_beat_err;
   logic [7:0]          ram_we;
   logic                ram_re;
   logic [AW-1:0]       ram_addr;
   logic [63:0]         ram_rdata;

   // Arbitration, beat qualification and RAM port control.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      grant_wr   = 1'b0;
      addr_oor   = 1'b0;
      w_fire     = 1'b0;
      w_beat_err = 1'b0;
      ram_we     = 8'h00;
      ram_re     = 1'b0;
      ram_addr   = '0;

      grant_wr   = i_awvalid && (!i_arvalid || !prio_rd);
      addr_oor   = (addr_q >= RAM_SIZE);
      w_fire     = (state == WR_DATA) && o_wready && i_wvalid;
      w_beat_err = addr_oor || (i_wlast && (beat_q != len_q));
      ram_we     = (w_fire && !addr_oor) ? i_wstrb : 8'h00;
      ram_re     = (state == RD_ISSUE);
      ram_addr   = AW'((addr_q & 32'(RAM_SIZE - 1)) >> 3);
   end

   // Out-of-range beats read as zero; outside a read beat the bus is zero.
   assign o_rdata = rdata_en_q ? ram_rdata : 64'h0;

   axi_mem_bram #(
      .DEPTH     (WORDS),
      .AW        (AW),
      .INIT_FILE (INIT_FILE)
   ) u_bram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (i_wdata),
      .rdata (ram_rdata)
   );

   // Transaction FSM with registered handshake and response outputs.
   // NOTE: all state here is updated with non-blocking assignments so every
   // register sees pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         prio_rd    <= 1'b0;
         is_wr      <= 1'b0;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_q     <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         err_q      <= 1'b0;
         rdata_en_q <= 1'b0;
         o_awready  <= 1'b0;
         o_arready  <= 1'b0;
         o_wready   <= 1'b0;
         o_bid      <= '0;
         o_bresp    <= RESP_OKAY;
         o_bvalid   <= 1'b0;
         o_rid      <= '0;
         o_rresp    <= RESP_OKAY;
         o_rlast    <= 1'b0;
         o_rvalid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_awvalid || i_arvalid) begin
                  is_wr     <= grant_wr;
                  o_awready <= grant_wr;
                  o_arready <= !grant_wr;
                  prio_rd   <= !prio_rd;
                  state     <= GRANT;
               end
            end

            GRANT: begin
               o_awready <= 1'b0;
               o_arready <= 1'b0;
               beat_q    <= '0;
               err_q     <= 1'b0;
               if (is_wr) begin
                  id_q     <= i_awid;
                  addr_q   <= i_awaddr;
                  len_q    <= i_awlen;
                  size_q   <= i_awsize;
                  burst_q  <= i_awburst;
                  o_wready <= 1'b1;
                  state    <= WR_DATA;
               end else begin
                  id_q     <= i_arid;
                  addr_q   <= i_araddr;
                  len_q    <= i_arlen;
                  size_q   <= i_arsize;
                  burst_q  <= i_arburst;
                  state    <= RD_ISSUE;
               end
            end

            WR_DATA: begin
               if (w_fire) begin
                  addr_q <= next_addr(addr_q, size_q, burst_q);
                  beat_q <= beat_q + 8'd1;
                  err_q  <= err_q || w_beat_err;
                  if (i_wlast) begin
                     o_wready <= 1'b0;
                     o_bvalid <= 1'b1;
                     o_bid    <= id_q;
                     o_bresp  <= (err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     state    <= WR_RESP;
                  end
               end
            end

            WR_RESP: begin
               if (i_bready) begin
                  o_bvalid <= 1'b0;
                  state    <= IDLE;
               end
            end

            RD_ISSUE: begin
               o_rvalid   <= 1'b1;
               o_rid      <= id_q;
               o_rlast    <= (beat_q == len_q);
               o_rresp    <= addr_oor ? RESP_SLVERR : RESP_OKAY;
               rdata_en_q <= !addr_oor;
               err_q      <= err_q || addr_oor;
               state      <= RD_DATA;
            end

            RD_DATA: begin
               if (i_rready) begin
                  o_rvalid   <= 1'b0;
                  o_rlast    <= 1'b0;
                  rdata_en_q <= 1'b0;
                  if (o_rlast) begin
                     state <= IDLE;
                  end else begin
                     addr_q <= next_addr(addr_q, size_q, burst_q);
                     beat_q <= beat_q + 8'd1;
                     state  <= RD_ISSUE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder.
module tb_axi_mem_responder;
   import axi_mem_pkg::*;

   localparam int TMO = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  i_awid, i_arid;
   logic [31:0] i_awaddr, i_araddr;
   logic [7:0]  i_awlen, i_arlen;
   logic [2:0]  i_awsize, i_arsize;
   logic [1:0]  i_awburst, i_arburst;
   logic        i_awvalid, i_arvalid;
   logic        o_awready, o_arready;
   logic [63:0] i_wdata;
   logic [7:0]  i_wstrb;
   logic        i_wlast, i_wvalid, o_wready;
   logic [5:0]  o_bid, o_rid;
   logic [1:0]  o_bresp, o_rresp;
   logic        o_bvalid, i_bready;
   logic [63:0] o_rdata;
   logic        o_rlast, o_rvalid, i_rready;

   int checks = 0;
   int errors = 0;

   logic [63:0] wd [8];
   logic [7:0]  ws [8];

   axi_mem_responder dut (
      .clk(clk), .rst(rst),
      .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen),
      .i_awsize(i_awsize), .i_awburst(i_awburst), .i_awvalid(i_awvalid),
      .o_awready(o_awready),
      .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen),
      .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arvalid(i_arvalid),
      .o_arready(o_arready),
      .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
      .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
      .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
      .o_rvalid(o_rvalid), .i_rready(i_rready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_aw(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
      int n;
      i_awid = id; i_awaddr = addr; i_awlen = len;
      i_awsize = 3'd3; i_awburst = BURST_INCR; i_awvalid = 1'b1;
      n = 0;
      while (!o_awready && n < TMO) begin tick(); n++; end
      if (!o_awready) check("aw_timeout", 64'd0, 64'd1);
      tick();
      i_awvalid = 1'b0;
   endtask

   task automatic do_ar(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
      int n;
      i_arid = id; i_araddr = addr; i_arlen = len;
      i_arsize = 3'd3; i_arburst = BURST_INCR; i_arvalid = 1'b1;
      n = 0;
      while (!o_arready && n < TMO) begin tick(); n++; end
      if (!o_arready) check("ar_timeout", 64'd0, 64'd1);
      tick();
      i_arvalid = 1'b0;
   endtask

   // Sends nbeats from wd/ws, raising wlast on the final beat sent.
   task automatic do_w(input int nbeats);
      int n;
      for (int i = 0; i < nbeats; i++) begin
         i_wdata = wd[i]; i_wstrb = ws[i];
         i_wlast = (i == nbeats - 1); i_wvalid = 1'b1;
         n = 0;
         while (!o_wready && n < TMO) begin tick(); n++; end
         if (!o_wready) check("w_timeout", 64'd0, 64'd1);
         tick();
      end
      i_wvalid = 1'b0; i_wlast = 1'b0;
   endtask

   task automatic get_b(input string tag, input logic [5:0] id, input logic [1:0] resp);
      int n;
      i_bready = 1'b1;
      n = 0;
      while (!o_bvalid && n < TMO) begin tick(); n++; end
      check({tag, "_bvalid"}, 64'(o_bvalid), 64'd1);
      check({tag, "_bid"}, 64'(o_bid), 64'(id));
      check({tag, "_bresp"}, 64'(o_bresp), 64'(resp));
      tick();
      i_bready = 1'b0;
   endtask

   task automatic wait_rvalid();
      int n;
      n = 0;
      while (!o_rvalid && n < TMO) begin tick(); n++; end
      if (!o_rvalid) check("r_timeout", 64'd0, 64'd1);
   endtask

   task automatic get_r(input string tag, input logic [5:0] id, input logic [63:0] data,
                        input logic last, input logic [1:0] resp);
      i_rready = 1'b1;
      wait_rvalid();
      check({tag, "_rdata"}, o_rdata, data);
      check({tag, "_rlast"}, 64'(o_rlast), 64'(last));
      check({tag, "_rresp"}, 64'(o_rresp), 64'(resp));
      check({tag, "_rid"}, 64'(o_rid), 64'(id));
      tick();
      i_rready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = 3'd3; i_awburst = BURST_INCR;
      i_awvalid = 1'b0;
      i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = 3'd3; i_arburst = BURST_INCR;
      i_arvalid = 1'b0;
      i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0;
      i_bready = 1'b0; i_rready = 1'b0;
      tick(); tick();

      // Reset state
      check("rst_awready", 64'(o_awready), 64'd0);
      check("rst_arready", 64'(o_arready), 64'd0);
      check("rst_wready", 64'(o_wready), 64'd0);
      check("rst_bvalid", 64'(o_bvalid), 64'd0);
      check("rst_rvalid", 64'(o_rvalid), 64'd0);
      check("rst_rlast", 64'(o_rlast), 64'd0);
      check("rst_ids", {52'd0, o_bid, o_rid}, 64'd0);
      check("rst_resps", {60'd0, o_bresp, o_rresp}, 64'd0);
      check("rst_rdata", o_rdata, 64'd0);
      rst = 1'b0;
      tick();

      // Single write then read
      do_aw(6'd5, 32'h100, 8'd0);
      wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
      do_w(1);
      get_b("single_wr", 6'd5, RESP_OKAY);
      do_ar(6'd5, 32'h100, 8'd0);
      get_r("single_rd", 6'd5, 64'h1122334455667788, 1'b1, RESP_OKAY);

      // Byte strobes
      do_aw(6'd1, 32'h200, 8'd0);
      wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
      do_w(1);
      get_b("strb_wr1", 6'd1, RESP_OKAY);
      do_aw(6'd1, 32'h200, 8'd0);
      wd[0] = 64'h0; ws[0] = 8'h0F;
      do_w(1);
      get_b("strb_wr2", 6'd1, RESP_OKAY);
      do_ar(6'd1, 32'h200, 8'd0);
      get_r("strb_rd", 6'd1, 64'hFFFFFFFF00000000, 1'b1, RESP_OKAY);

      // INCR burst: preload index values, read back with a stall on beat 3
      for (int i = 0; i < 8; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
      do_aw(6'd2, 32'h0, 8'd7);
      do_w(8);
      get_b("burst_wr", 6'd2, RESP_OKAY);
      do_ar(6'd3, 32'h0, 8'd7);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            i_rready = 1'b0;
            wait_rvalid();
            check("stall_rdata0", o_rdata, 64'd3);
            for (int k = 0; k < 4; k++) begin
               tick();
               check("stall_rvalid", 64'(o_rvalid), 64'd1);
               check("stall_rdata", o_rdata, 64'd3);
               check("stall_rlast", 64'(o_rlast), 64'd0);
            end
         end
         get_r("burst_rd", 6'd3, 64'(i), (i == 7), RESP_OKAY);
      end

      // Simultaneous AW+AR after reset: W, R, W, R
      rst = 1'b1; tick(); rst = 1'b0;
      for (int r = 0; r < 2; r++) begin
         i_awid = 6'd10; i_awaddr = 32'h300; i_awlen = 8'd0; i_awsize = 3'd3;
         i_awburst = BURST_INCR; i_awvalid = 1'b1;
         i_arid = 6'd11; i_araddr = (r == 0) ? 32'h100 : 32'h300; i_arlen = 8'd0;
         i_arsize = 3'd3; i_arburst = BURST_INCR; i_arvalid = 1'b1;
         tick();
         check("tie_awready", 64'(o_awready), 64'd1);
         check("tie_arready", 64'(o_arready), 64'd0);
         tick();
         i_awvalid = 1'b0;
         wd[0] = (r == 0) ? 64'hA5A5A5A5A5A5A5A5 : 64'h5A5A5A5A5A5A5A5A; ws[0] = 8'hFF;
         do_w(1);
         get_b("tie_wr", 6'd10, RESP_OKAY);
         do_ar(6'd11, i_araddr, 8'd0);
         get_r("tie_rd", 6'd11, (r == 0) ? 64'h1122334455667788 : 64'h5A5A5A5A5A5A5A5A,
               1'b1, RESP_OKAY);
      end

      // Out-of-range read and write
      do_ar(6'd4, 32'h10000, 8'd0);
      get_r("oor_rd", 6'd4, 64'd0, 1'b1, RESP_SLVERR);
      do_aw(6'd4, 32'h10000, 8'd0);
      wd[0] = 64'hDEADBEEFDEADBEEF; ws[0] = 8'hFF;
      do_w(1);
      get_b("oor_wr", 6'd4, RESP_SLVERR);
      do_ar(6'd4, 32'h0, 8'd0);
      get_r("oor_alias", 6'd4, 64'd0, 1'b1, RESP_OKAY);

      // Early wlast: len 3, only 2 beats
      wd[0] = 64'h1; wd[1] = 64'h2; ws[0] = 8'hFF; ws[1] = 8'hFF;
      do_aw(6'd6, 32'h400, 8'd3);
      do_w(2);
      get_b("early_wlast", 6'd6, RESP_SLVERR);

      // Reset during beat 2 of a read burst
      do_ar(6'd8, 32'h0, 8'd3);
      get_r("rst_burst", 6'd8, 64'd0, 1'b0, RESP_OKAY);
      get_r("rst_burst", 6'd8, 64'd1, 1'b0, RESP_OKAY);
      wait_rvalid();
      check("rst_beat2_data", o_rdata, 64'd2);
      rst = 1'b1;
      tick();
      check("midrst_rvalid", 64'(o_rvalid), 64'd0);
      check("midrst_rlast", 64'(o_rlast), 64'd0);
      rst = 1'b0;
      i_rready = 1'b1;
      tick(); tick();
      check("midrst_quiet", {62'd0, o_rvalid, o_bvalid}, 64'd0);
      i_rready = 1'b0;
      do_ar(6'd7, 32'h100, 8'd0);
      get_r("post_rst", 6'd7, 64'h1122334455667788, 1'b1, RESP_OKAY);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
